ssd_display_driver: RTL and testbench
=====================================

# ssd_display_driver

Consumer side of the datapath's 13-bit `ssd` display value: takes the binary number the datapath drives on `ssd` and drives a 4-digit, common-anode seven-segment display on the board. A sequential double-dabble converter turns the binary value into 4 BCD digits. A refresh counter time-multiplexes the digits onto one shared segment bus. It sits at the top level between `Datapath` and the FPGA display pins.

## Interface
- `WIDTH`, 13: binary input width. Maximum value 8191 fits in 4 BCD digits.
- `DIGIT_CYCLES`, 50000: clk cycles each digit stays lit. Must be ≥2.
- `BLANK_LZ`, 1: when 1, leading-zero digits are blanked.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `num`  in  WIDTH  binary value to display; connect to the datapath `ssd` output.
- `bcd`  out  16  last completed conversion as {thousands, hundreds, tens, ones}.
- `busy`  out  1  high while a conversion is in progress.
- `anode`  out  4  digit enables, active-low; `anode[0]` is the ones digit (rightmost).
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Converter FSM states: IDLE, SHIFT, DONE. It runs continuously.
  - IDLE: capture `num` into `bin_sh`, clear `bcd_work`, clear `bit_cnt`, go to SHIFT.
  - SHIFT, each cycle:
    - Add 3 to every nibble of `bcd_work` that is ≥5.
    - Shift {`bcd_work`, `bin_sh`} left by one.
    - Increment `bit_cnt`.
    - After the WIDTH-th shift, go to DONE.
  - DONE: copy `bcd_work` to `bcd`, go to IDLE.
- Arithmetic: `bcd_work` is 16 bits; the add-3 step never overflows a nibble for WIDTH=13. `bit_cnt` is 4 bits.
- `busy` = (state != IDLE).
- Changes on `num` outside the IDLE sample cycle are ignored until the next IDLE.
- Refresh:
  - `tick_cnt` counts 0 to DIGIT_CYCLES-1.
  - On wrap, `digit_sel` (2 bits) increments. It wraps 3→0.
- Digit decode, segment patterns:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - Nibble >9 → 1111111.
- Blanking: with `BLANK_LZ`=1, a digit is blanked when it and every higher digit are 0. The ones digit is never blanked. A blanked digit drives `anode`=1111 and `seg`=1111111 for its slot.
- `anode` and `seg` are registered from `digit_sel` and `bcd`, so there is no combinational glitching on the pins.

## Timing
- Reset (`Reset`=0 at an edge), effective at that edge:
  - state = IDLE, `bcd` = 16'h0000, `busy` = 0.
  - `bin_sh`, `bcd_work`, `bit_cnt`, `tick_cnt`, `digit_sel` = 0.
  - `anode` = 1110, `seg` = 1000000.
- Reset mid-SHIFT aborts the conversion; there is no partial write to `bcd`.
- Conversion period is WIDTH+2 = 15 cycles. With `num` sampled at edge k:
  - SHIFT occupies edges k+1..k+13.
  - `bcd` updates at edge k+14.
  - The next sample is taken at edge k+15.
- Worst-case latency from a `num` change to `bcd` is 29 cycles.
- `anode`/`seg` lag `digit_sel` and `bcd` by 1 cycle.
- Each digit is lit for exactly DIGIT_CYCLES cycles; one full scan is 4·DIGIT_CYCLES cycles.
- A `bcd` update mid-slot takes effect in the current slot, one cycle later.

## Structure
- Shared package `ssd_pkg` holds:
  - the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the ten segment-pattern constants plus `SEG_BLANK`;
  - `ANODE_OFF` = 4'b1111.
- Sub-module `bin2bcd_seq` contains the converter FSM. Its ports are `clk`, `Reset`, `bin`, `bcd`, `busy`.
- The top level `ssd_display_driver` owns the refresh counter, blanking, decode and output registers.

## Test plan
- **Reset:** hold `Reset`=0 for 3 cycles with `num`=1234. Required: `bcd`=0000, `busy`=0, `anode`=1110, `seg`=1000000. After release, `bcd`=16'h1234 by cycle 15.
- **Scan order:** `num`=1234, `DIGIT_CYCLES`=4. Required sequence, each held 4 cycles:
  - `anode` 1110 / `seg` 0011001
  - 1101 / 0110000
  - 1011 / 0100100
  - 0111 / 1111001
  - Then it returns to 1110, covering the 3→0 wrap.
- **Maximum value:** `num`=8191 → `bcd`=16'h8191. `num`=0 → `anode[0]` active with `seg`=1000000 and digits 1–3 blanked.
- **Blanking:** `num`=7 with `BLANK_LZ`=1 → slots 1–3 give `anode`=1111, slot 0 gives `seg`=1111000. With `BLANK_LZ`=0, digits 1–3 show 1000000.
- **Mid-conversion change:** change `num` from 42 to 99 one cycle after the IDLE sample. Required: `bcd`=0042 at k+14, then `bcd`=0099 at k+29.
- **Reset mid-SHIFT:** `Reset`=0 at edge k+5 of a conversion. Required: `busy`=0 and `bcd`=0000 at the next edge. After release, a clean conversion completes in 15 cycles.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display driver.
// Holds the binary-to-BCD converter state encoding, the active-low
// segment patterns ({g,f,e,d,c,b,a}) and the all-off anode pattern.
// No ports; imported by bin2bcd_seq and ssd_display_driver.
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Non-decimal nibbles show nothing rather than a misleading glyph.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: binary to 4 packed BCD digits.
// Runs continuously: sample (IDLE), WIDTH shift cycles (SHIFT), publish
// (DONE), giving a fixed WIDTH+2 cycle conversion period.
// Ports:
//   clk   - clock, rising edge
//   Reset - synchronous active-low reset
//   bin   - binary value, sampled only in IDLE
//   bcd   - last completed conversion {thousands,hundreds,tens,ones}
//   busy  - high while a conversion is in progress
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] bin,
  output logic [15:0]      bcd,
  output logic             busy
);

  localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

  conv_state_t      state, state_next;
  logic [WIDTH-1:0] bin_sh, bin_sh_next;
  logic [15:0]      bcd_work, bcd_work_next;
  logic [3:0]       bit_cnt, bit_cnt_next;
  logic [15:0]      bcd_next;
  logic [15:0]      adjusted;
  logic [15+WIDTH:0] shifted;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state    <= IDLE;
      bin_sh   <= '0;
      bcd_work <= '0;
      bit_cnt  <= '0;
      bcd      <= '0;
    end else begin
      state    <= state_next;
      bin_sh   <= bin_sh_next;
      bcd_work <= bcd_work_next;
      bit_cnt  <= bit_cnt_next;
      bcd      <= bcd_next;
    end
  end

  always_comb begin
    state_next    = state;
    bin_sh_next   = bin_sh;
    bcd_work_next = bcd_work;
    bit_cnt_next  = bit_cnt;
    bcd_next      = bcd;

    // Add-3 correction so the following left shift carries into the next decade.
    adjusted = bcd_work;
    for (int i = 0; i < 4; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adjusted, bin_sh} << 1;

    case (state)
      IDLE: begin
        bin_sh_next   = bin;
        bcd_work_next = '0;
        bit_cnt_next  = '0;
        state_next    = SHIFT;
      end
      SHIFT: begin
        bcd_work_next = shifted[15+WIDTH:WIDTH];
        bin_sh_next   = shifted[WIDTH-1:0];
        bit_cnt_next  = bit_cnt + 4'd1;
        if (bit_cnt == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bcd_next   = bcd_work;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/ssd_display_driver.sv
// Four-digit common-anode seven-segment driver for the datapath ssd value.
// Converts num to BCD continuously and time-multiplexes the digits onto a
// shared segment bus, optionally blanking leading zeros.
// Ports:
//   clk   - clock, rising edge
//   Reset - synchronous active-low reset
//   num   - binary value to display
//   bcd   - last completed conversion {thousands,hundreds,tens,ones}
//   busy  - converter busy
//   anode - digit enables, active-low, anode[0] = ones digit
//   seg   - segments {g,f,e,d,c,b,a}, active-low
module ssd_display_driver
  import ssd_pkg::*;
#(
  parameter int WIDTH        = 13,
  parameter int DIGIT_CYCLES = 50000,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] num,
  output logic [15:0]      bcd,
  output logic             busy,
  output logic [3:0]       anode,
  output logic [6:0]       seg
);

  localparam int TICK_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_CYCLES - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic [1:0]        digit_sel;
  logic [3:0]        digit;
  logic [3:0]        lead_zero;
  logic              blank;
  logic [3:0]        anode_next;
  logic [6:0]        seg_next;

  bin2bcd_seq #(
    .WIDTH(WIDTH)
  ) u_conv (
    .clk  (clk),
    .Reset(Reset),
    .bin  (num),
    .bcd  (bcd),
    .busy (busy)
  );

  always_ff @(posedge clk) begin
    if (!Reset) begin
      tick_cnt  <= '0;
      digit_sel <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt  <= '0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      tick_cnt  <= tick_cnt + 1'b1;
    end
  end

  always_comb begin
    case (digit_sel)
      2'd0:    digit = bcd[3:0];
      2'd1:    digit = bcd[7:4];
      2'd2:    digit = bcd[11:8];
      default: digit = bcd[15:12];
    endcase

    // lead_zero[i] means digit i and every digit above it are zero.
    lead_zero[3] = (bcd[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (bcd[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (bcd[7:4] == 4'd0);
    lead_zero[0] = 1'b0;

    blank      = BLANK_LZ && lead_zero[digit_sel];
    anode_next = blank ? ANODE_OFF : ~(4'b0001 << digit_sel);
    seg_next   = blank ? SEG_BLANK : seg_decode(digit);
  end

  // Registered pins keep the display free of decode glitches.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      anode <= 4'b1110;
      seg   <= SEG_0;
    end else begin
      anode <= anode_next;
      seg   <= seg_next;
    end
  end

endmodule

// File: tb/tb_ssd_display_driver.sv
// Self-checking bench for ssd_display_driver. A reference model at the
// clock edge predicts each conversion result (decimal arithmetic) and the
// expected pins for every cycle; a monitor on the falling edge compares.
module tb_ssd_display_driver;

  localparam int DC     = 4;
  localparam int PERIOD = 15;

  logic        clk   = 1'b0;
  logic        Reset = 1'b0;
  logic [12:0] num   = 13'd0;

  logic [15:0] bcd, bcd_nb;
  logic        busy, busy_nb;
  logic [3:0]  anode, anode_nb;
  logic [6:0]  seg, seg_nb;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int value;
    int due;
  } conv_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] sg;
    logic [3:0] an_nb;
    logic [6:0] sg_nb;
  } disp_t;

  conv_t conv_q[$];
  disp_t disp_q[$];

  int cyc        = 0;
  int since      = 0;
  int edges      = 0;
  int disp_val   = 0;
  int pend_val   = 0;
  int pend_due   = 0;
  bit pend_valid = 1'b0;
  bit rst_at_edge = 1'b0;
  bit prev_busy    = 1'b0;
  bit prev_busy_nb = 1'b0;

  ssd_display_driver #(
    .WIDTH(13), .DIGIT_CYCLES(DC), .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk), .Reset(Reset), .num(num), .bcd(bcd), .busy(busy),
    .anode(anode), .seg(seg)
  );

  ssd_display_driver #(
    .WIDTH(13), .DIGIT_CYCLES(DC), .BLANK_LZ(1'b0)
  ) dut_nb (
    .clk(clk), .Reset(Reset), .num(num), .bcd(bcd_nb), .busy(busy_nb),
    .anode(anode_nb), .seg(seg_nb)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // {anode, seg} for decimal value v shown in digit slot 'slot'.
  function automatic logic [10:0] ref_display(input int v, input int slot, input bit blank_lz);
    int d;
    logic [3:0] an;
    d = (v / pow10(slot)) % 10;
    if (blank_lz && slot != 0 && v < pow10(slot)) return {4'b1111, 7'b1111111};
    an = ~(4'b0001 << slot);
    return {an, ref_seg(d)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [12:0] value, input int hold);
    num = value;
    repeat (hold) @(negedge clk);
  endtask

  // Reference model: conversions sampled every PERIOD edges after reset
  // release, result visible PERIOD-1 edges later; display slot advances
  // every DC edges and the pins show the previous cycle's state.
  always @(posedge clk) begin
    int prev_val;
    disp_t d;
    conv_t c;
    logic [10:0] e1, e0;
    cyc++;
    rst_at_edge = Reset;
    if (!Reset) begin
      since      = 0;
      edges      = 0;
      disp_val   = 0;
      pend_valid = 1'b0;
      conv_q.delete();
      d.an = 4'b1110; d.sg = 7'b1000000;
      d.an_nb = 4'b1110; d.sg_nb = 7'b1000000;
      disp_q.push_back(d);
    end else begin
      prev_val = disp_val;
      edges++;
      if (pend_valid && pend_due == cyc) begin
        disp_val   = pend_val;
        pend_valid = 1'b0;
      end
      if (since % PERIOD == 0) begin
        pend_val   = int'(num);
        pend_due   = cyc + PERIOD - 1;
        pend_valid = 1'b1;
        c.value = pend_val;
        c.due   = pend_due;
        conv_q.push_back(c);
      end
      since++;
      e1 = ref_display(prev_val, ((edges - 1) / DC) % 4, 1'b1);
      e0 = ref_display(prev_val, ((edges - 1) / DC) % 4, 1'b0);
      d.an = e1[10:7]; d.sg = e1[6:0];
      d.an_nb = e0[10:7]; d.sg_nb = e0[6:0];
      disp_q.push_back(d);
    end
  end

  // Monitor: compares pins every cycle and bcd whenever a conversion ends.
  always @(negedge clk) begin
    bit fell, fell_nb;
    disp_t d;
    conv_t c;
    if (disp_q.size() > 0) begin
      d = disp_q.pop_front();
      checkOutput("anode", 32'(anode), 32'(d.an));
      checkOutput("seg", 32'(seg), 32'(d.sg));
      checkOutput("anode_nb", 32'(anode_nb), 32'(d.an_nb));
      checkOutput("seg_nb", 32'(seg_nb), 32'(d.sg_nb));
    end
    fell    = prev_busy && !busy;
    fell_nb = prev_busy_nb && !busy_nb;
    if (rst_at_edge) begin
      if (conv_q.size() > 0 && conv_q[0].due == cyc) begin
        c = conv_q.pop_front();
        checkOutput("done_timing", 32'(fell), 32'd1);
        checkOutput("bcd", 32'(bcd), 32'(to_bcd(c.value)));
        checkOutput("bcd_nb", 32'(bcd_nb), 32'(to_bcd(c.value)));
      end else begin
        checkOutput("spurious_done", 32'(fell), 32'd0);
        checkOutput("spurious_done_nb", 32'(fell_nb), 32'd0);
      end
    end
    prev_busy    = busy;
    prev_busy_nb = busy_nb;
  end

  initial begin
    int guard;
    Reset = 1'b0;
    num   = 13'd1234;
    repeat (3) @(negedge clk);
    checkOutput("reset_bcd", 32'(bcd), 32'h0000);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    Reset = 1'b1;

    // Scan order, maximum value, zero and leading-zero blanking.
    applyStimulus(13'd1234, 40);
    applyStimulus(13'd8191, 40);
    applyStimulus(13'd0, 40);
    applyStimulus(13'd7, 40);

    // Change num one cycle after the sample edge.
    guard = 0;
    while (since % PERIOD != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    num = 13'd42;
    @(negedge clk);
    applyStimulus(13'd99, 40);

    // Reset at edge k+5 of a conversion.
    guard = 0;
    while (since % PERIOD != 5 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    Reset = 1'b0;
    @(negedge clk);
    checkOutput("midshift_busy", 32'(busy), 32'd0);
    checkOutput("midshift_bcd", 32'(bcd), 32'h0000);
    Reset = 1'b1;
    applyStimulus(13'($urandom_range(0, 8191)), 40);

    repeat (30) begin
      applyStimulus(13'($urandom_range(0, 8191)), int'($urandom_range(1, 40)));
    end
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
